// File: rtl/img_line_buf.sv
// Streaming line buffer: keeps the last K-1 image rows and emits one vertically
// aligned K-pixel column per accepted pixel once K-1 rows have been buffered.
module img_line_buf #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32,
    parameter int unsigned K      = 3
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [K*DATA_W-1:0]       out_data,
    output logic [$clog2(IMG_H)-1:0]  out_row,
    output logic [$clog2(IMG_W)-1:0]  out_col,
    output logic                      frame_done
);

    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned COL_W = $clog2(IMG_W);

    typedef enum logic [0:0] {StFill, StStream} state_e;

    state_e             r_state, w_state_nxt;
    logic [ROW_W-1:0]   r_row, w_row_nxt;
    logic [COL_W-1:0]   r_col, w_col_nxt;

    logic [DATA_W-1:0]  r_line [K-1][IMG_W];

    logic               r_out_valid;
    logic [K*DATA_W-1:0] r_out_data;
    logic [ROW_W-1:0]   r_out_row;
    logic [COL_W-1:0]   r_out_col;
    logic               r_frame_done;

    logic               w_accept;
    logic               w_emit;
    logic               w_last_col;
    logic               w_last_row;
    logic [K*DATA_W-1:0] w_column;

    // Reset gates readiness so no pixel is taken while the block is held in reset.
    assign in_ready   = rst & en & (~r_out_valid | out_ready);
    assign w_accept   = in_valid & in_ready;
    assign w_last_col = (r_col == COL_W'(IMG_W - 1));
    assign w_last_row = (r_row == ROW_W'(IMG_H - 1));
    assign w_emit     = w_accept & (r_state == StStream);

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        if (w_accept) begin
            if (w_last_col) begin
                w_col_nxt = '0;
                w_row_nxt = w_last_row ? '0 : r_row + 1'b1;
            end else begin
                w_col_nxt = r_col + 1'b1;
            end
            unique case (r_state)
                StFill: begin
                    if (w_last_col && (r_row == ROW_W'(K - 2))) begin
                        w_state_nxt = StStream;
                    end
                end
                StStream: begin
                    if (w_last_col && w_last_row) begin
                        w_state_nxt = StFill;
                    end
                end
                default: w_state_nxt = StFill;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            r_state <= StFill;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
        end
    end

    // Line memories are intentionally not reset; FILL rewrites them before use.
    always_ff @(posedge sys_clk) begin
        if (w_accept) begin
            r_line[0][r_col] <= in_data;
            for (int j = 1; j < K - 1; j++) begin
                r_line[j][r_col] <= r_line[j-1][r_col];
            end
        end
    end

    // Slice K-1 is the incoming pixel, slice 0 the oldest buffered row.
    always_comb begin
        w_column = '0;
        w_column[(K-1)*DATA_W +: DATA_W] = in_data;
        for (int i = 0; i < K - 1; i++) begin
            w_column[i*DATA_W +: DATA_W] = r_line[K-2-i][r_col];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_frame_done <= 1'b0;
        end else if (en) begin
            r_frame_done <= 1'b0;
            if (w_accept) begin
                r_out_data   <= w_column;
                r_out_row    <= r_row;
                r_out_col    <= r_col;
                r_out_valid  <= w_emit;
                r_frame_done <= w_emit & w_last_row & w_last_col;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end else begin
            r_frame_done <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_img_line_buf.sv
// Self-checking bench for img_line_buf: directed scenarios plus randomized
// handshakes, checked against an image-array reference model.
module tb_img_line_buf;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int K  = 3;

    logic              sys_clk;
    logic              rst;
    logic              en;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic              out_ready;
    logic [K*DW-1:0]   out_data;
    logic [1:0]        out_row;
    logic [1:0]        out_col;
    logic              frame_done;

    img_line_buf #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(K)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the current frame as an image plus the pending output column.
    logic [DW-1:0]   pix [H][W];
    int              mr, mc;
    int              base;
    bit              m_valid;
    logic [K*DW-1:0] m_data;
    int              m_row, m_col;
    bit              m_fd;
    bit              last_acc;

    // Per-frame observations of the DUT.
    int              xfers, fd_cnt;
    bit              seen_first;
    logic [K*DW-1:0] first_obs, last_obs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        xfers      = 0;
        fd_cnt     = 0;
        seen_first = 1'b0;
        first_obs  = '0;
        last_obs   = '0;
    endtask

    task automatic step(input bit r, input bit e, input bit v, input bit ordy);
        bit acc;
        rst       = r;
        en        = e;
        in_valid  = v;
        out_ready = ordy;
        in_data   = DW'(base + 4 * mr + mc);
        #1;
        chk("in_ready", 32'(in_ready), 32'(r & e & (~m_valid | ordy)));
        if (r && e && out_valid === 1'b1 && ordy) begin
            xfers++;
            last_obs = out_data;
        end
        acc = r & e & v & (~m_valid | ordy);
        last_acc = acc;
        @(posedge sys_clk);
        #1;
        if (!r) begin
            m_valid = 1'b0; m_data = '0; m_row = 0; m_col = 0; m_fd = 1'b0;
            mr = 0; mc = 0;
        end else if (e) begin
            m_fd = 1'b0;
            if (acc) begin
                pix[mr][mc] = in_data;
                if (mr >= K - 1) begin
                    m_valid = 1'b1;
                    for (int i = 0; i < K; i++) m_data[i*DW +: DW] = pix[mr-(K-1)+i][mc];
                    m_row = mr;
                    m_col = mc;
                    m_fd  = (mr == H - 1) && (mc == W - 1);
                end else begin
                    m_valid = 1'b0;
                end
                mc++;
                if (mc == W) begin
                    mc = 0;
                    mr = (mr == H - 1) ? 0 : mr + 1;
                end
            end else if (m_valid && ordy) begin
                m_valid = 1'b0;
            end
        end else begin
            m_fd = 1'b0;
        end
        if (out_valid === 1'b1 && !seen_first) begin
            seen_first = 1'b1;
            first_obs  = out_data;
        end
        if (frame_done === 1'b1) fd_cnt++;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        if (m_valid || !r) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_row", 32'(out_row), 32'(m_row));
            chk("out_col", 32'(out_col), 32'(m_col));
        end
    endtask

    task automatic feed(input int n, input int vpct, input int rpct, input int epct);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 2000) begin
            bit v, o, e;
            v = ($urandom_range(99) < vpct);
            o = ($urandom_range(99) < rpct);
            e = ($urandom_range(99) < epct);
            step(1'b1, e, v, o);
            if (last_acc) got++;
            cyc++;
        end
        chk("feed_count", 32'(got), 32'(n));
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic frame_check(input string tag, input logic [K*DW-1:0] f,
                               input logic [K*DW-1:0] l, input int nx, input int nfd);
        chk({tag, "_first"}, 32'(first_obs), 32'(f));
        chk({tag, "_last"}, 32'(last_obs), 32'(l));
        chk({tag, "_cols"}, 32'(xfers), 32'(nx));
        chk({tag, "_fdone"}, 32'(fd_cnt), 32'(nfd));
    endtask

    initial begin
        base = 0; mr = 0; mc = 0;
        m_valid = 1'b0; m_data = '0; m_row = 0; m_col = 0; m_fd = 1'b0;
        last_acc = 1'b0;
        rst = 1'b0; en = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = '0;
        clear_stats();

        // Reset held with in_valid asserted.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);

        // Plain frame at full throughput.
        clear_stats();
        feed(16, 100, 100, 100);
        drain();
        frame_check("t2", 24'h080400, 24'h0F0B07, 8, 1);

        // Backpressure mid-stream.
        clear_stats();
        feed(10, 100, 100, 100);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            chk("bp_hold_data", 32'(out_data), 32'h090501);
        end
        feed(6, 100, 100, 100);
        drain();
        frame_check("t3", 24'h080400, 24'h0F0B07, 8, 1);

        // Enable dropped after pixel 5.
        clear_stats();
        feed(5, 100, 100, 100);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'($urandom_range(1)));
        feed(11, 100, 100, 100);
        drain();
        frame_check("t4", 24'h080400, 24'h0F0B07, 8, 1);

        // Two back-to-back frames, second offset by 100.
        clear_stats();
        feed(16, 100, 100, 100);
        seen_first = 1'b0;
        base = 100;
        feed(16, 100, 100, 100);
        drain();
        frame_check("t5", 24'h6C6864, 24'h736F6B, 16, 2);
        base = 0;

        // Reset pulse mid-frame, then a clean frame.
        feed(10, 100, 100, 100);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        clear_stats();
        feed(16, 100, 100, 100);
        drain();
        frame_check("t6", 24'h080400, 24'h0F0B07, 8, 1);

        // Randomized handshakes and enable over several frames.
        clear_stats();
        for (int f = 0; f < 3; f++) begin
            base = $urandom_range(200);
            feed(16, 60, 60, 85);
        end
        drain();
        chk("rand_cols", 32'(xfers), 32'd24);
        chk("rand_fdone", 32'(fd_cnt), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
